approx_pattern_matcher: RTL and testbench
=========================================

Name: approx_pattern_matcher

Overview:
- Approximate pattern matcher (APM) with masked bit compare.
- Slides a 16-bit pattern, with a per-bit don't-care mask, across a 32-bit text word.
- Scores all 17 alignments, then reports the best score and a one-hot-per-alignment map of where that best score occurs.
- Single-cycle-latency registered datapath; sits in the search/compare pipeline as a per-word scoring stage.

Parameters:
- none (widths fixed: pattern 16, text 32, alignments 17)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b valid this cycle; sampled on rising clk
- a  input  32  a[31:16] = pattern P; a[15:0] = care mask M (1 = compare bit, 0 = don't care)
- b  input  32  text word T
- out_valid  output  1  y holds the result of the input accepted on the previous cycle
- y  output  32  result word, fields below

Behaviour:
- Reset: asynchronous on rst_n low. y = 32'h0 and out_valid = 0 immediately. Both are held until the first rising clk after rst_n deasserts with in_valid = 1.
- Alignment k (k = 0..16): window W_k = T[k+15:k]; pattern bit i aligns to T[k+i].
- Score: score_k = count of i in 0..15 where M[i] == 0 or T[k+i] == P[i]. Range 0..16 (5 bits). Don't-care bits always count as matches.
- Top score: top = max over k of score_k.
- Match map: loc[k] = 1 iff score_k == top. At least one bit is always set.
- Output format:
  - y[28:24] = top
  - y[16:0] = loc (bit k = alignment k)
  - y[31:29] = 0 and y[23:17] = 0 always
- Latency: scoring is combinational from a/b. Result is registered on the rising clk where in_valid = 1. On that same edge, out_valid is set to 1 and y is updated.
- in_valid = 0 at a clock edge: out_valid clears to 0; y holds its last value.
- Throughput: one word per clock. Back-to-back in_valid yields back-to-back results in order with no bubbles.
- Mask all zero: every score = 16, so top = 16 and loc = 17'h1FFFF.
- Ties: every tied alignment is flagged. There is no priority encoding.
- Reset mid-stream: any in-flight result is discarded; there is no partial output.
- Implementation: 17 masked XNOR banks, 17 16-input popcounts, 5-bit max-reduction tree, 17 equality compares, output registers.

Test Plan:
- Reset: assert rst_n = 0 mid-run with in_valid high -> y = 32'h0 and out_valid = 0 immediately, without waiting for clk; first valid after release produces a correct result one cycle later.
- a = 32'h00000000, b = any (e.g. 32'h0000FFFE), in_valid = 1 -> next cycle y = 32'h1001FFFF, out_valid = 1.
- a = 32'hFFFFFFFF, b = 32'h0000FFFF -> y = 32'h10000001 (only k = 0 scores 16; score_k = 16 - k). Then a = 32'h0000FFFF with the same b -> y = 32'h10010000 (only k = 16 scores 16).
- a = 32'hAAAAFFFF, b = 32'hAAAAAAAA -> even alignments score 16, odd score 0 -> y = 32'h10015555.
- a = 32'hFFFF00FF, b = 32'h00000000 -> every score 8 (don't-care bits only) -> y = 32'h0801FFFF. Same a with b = 32'h000000FF -> y = 32'h10000001.
- Streaming: the five vectors above on consecutive cycles with in_valid held high -> the five results appear on consecutive cycles in the same order, with out_valid continuously 1. Drop in_valid for one cycle -> out_valid = 0 for exactly that cycle while y holds.

Source files
------------

// File: rtl/approx_pattern_matcher.sv
// Masked 16-bit pattern scored at all 17 alignments of a 32-bit text word; reports best score and tie map.
// Latency: 1 cycle (combinational scoring, registered result on the accepting clk edge).
// Backpressure: none; accepts one word per clock whenever in_valid is high, never stalls.
module approx_pattern_matcher (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] y
);

  localparam int NALIGN = 17;
  localparam int PLEN   = 16;

  logic [15:0] pat;
  logic [15:0] care;
  logic [4:0]  score [NALIGN];
  logic [4:0]  top;
  logic [16:0] loc;

  logic        vld_q, vld_d;
  logic [31:0] y_q, y_d;

  assign pat  = a[31:16];
  assign care = a[15:0];

  // Per-alignment popcount of masked XNOR; don't-care bits always count as matches.
  always_comb begin
    for (int k = 0; k < NALIGN; k++) begin
      score[k] = 5'd0;
      for (int i = 0; i < PLEN; i++) begin
        score[k] = score[k] + 5'(~care[i] | ~(b[k+i] ^ pat[i]));
      end
    end
  end

  // Max reduction over all alignments, then flag every alignment that reaches it.
  always_comb begin
    top = 5'd0;
    loc = 17'd0;
    for (int k = 0; k < NALIGN; k++) begin
      if (score[k] > top) top = score[k];
    end
    for (int k = 0; k < NALIGN; k++) begin
      loc[k] = (score[k] == top);
    end
  end

  // Next-state: capture a new result only on accepted input, otherwise hold y.
  always_comb begin
    vld_d = in_valid;
    y_d   = y_q;
    if (in_valid) y_d = {3'b000, top, 7'b0000000, loc};
  end

  // Output registers; reset discards any in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      y_q   <= 32'h0;
    end else begin
      vld_q <= vld_d;
      y_q   <= y_d;
    end
  end

  assign out_valid = vld_q;
  assign y         = y_q;

endmodule

// File: tb/tb_approx_pattern_matcher.sv
// Self-checking bench for approx_pattern_matcher: directed vectors, streaming, async reset, random.
// Latency: expects results one clock after each accepted input.
// Backpressure: none exercised; in_valid gaps check out_valid drop and y hold.
module tb_approx_pattern_matcher;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] y;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  logic [31:0] va [5];
  logic [31:0] vb [5];
  logic [31:0] vy [5];

  approx_pattern_matcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: shift the text per alignment and count compared-equal or don't-care bits.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv);
    int          sc [17];
    int          best;
    logic [16:0] m;
    logic [31:0] w;
    best = 0;
    m    = '0;
    for (int k = 0; k < 17; k++) begin
      w     = bv >> k;
      sc[k] = 0;
      for (int i = 0; i < 16; i++)
        if (av[i] == 1'b0 || w[i] == av[16+i]) sc[k]++;
      if (sc[k] > best) best = sc[k];
    end
    for (int k = 0; k < 17; k++) m[k] = (sc[k] == best);
    return {3'b000, best[4:0], 7'b0000000, m};
  endfunction

  // Drive one cycle of stimulus (called #1 after a posedge), then check the result #1 after the next edge.
  task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] expv, input string tag);
    in_valid = v;
    a        = av;
    b        = bv;
    if (v) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 32'(out_valid), 32'(v));
    if (v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_sb got=empty exp=entry", tag);
      end else begin
        last_exp = exp_q.pop_front();
        chk({tag, "_y"}, y, last_exp);
      end
    end else begin
      chk({tag, "_hold"}, y, last_exp);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rv;
    n_checks = 0;
    n_fail   = 0;
    last_exp = 32'h0;
    va[0] = 32'h00000000; vb[0] = 32'h0000FFFE; vy[0] = 32'h1001FFFF;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'h0000FFFF; vy[1] = 32'h10000001;
    va[2] = 32'h0000FFFF; vb[2] = 32'h0000FFFF; vy[2] = 32'h10010000;
    va[3] = 32'hAAAAFFFF; vb[3] = 32'hAAAAAAAA; vy[3] = 32'h10015555;
    va[4] = 32'hFFFF00FF; vb[4] = 32'h00000000; vy[4] = 32'h0801FFFF;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", y, 32'h0);
    chk("rst_vld", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    // Directed vectors, each separated by an idle cycle.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, va[i], vb[i], vy[i], $sformatf("dir%0d", i));
      step(1'b0, '0, '0, '0, $sformatf("gap%0d", i));
    end
    step(1'b1, 32'hFFFF00FF, 32'h000000FF, 32'h10000001, "dir5");

    // Streaming: five back-to-back, one bubble, then one more.
    for (int i = 0; i < 5; i++) step(1'b1, va[i], vb[i], vy[i], $sformatf("str%0d", i));
    step(1'b0, 32'h12345678, 32'h9ABCDEF0, '0, "bubble");
    step(1'b1, va[3], vb[3], vy[3], "str5");

    // Async reset mid-stream with in_valid high.
    in_valid = 1'b1;
    a        = va[1];
    b        = vb[1];
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_y", y, 32'h0);
    chk("mrst_vld", 32'(out_valid), 32'h0);
    exp_q.delete();
    last_exp = 32'h0;
    @(posedge clk);
    #1;
    chk("mrst_hold_y", y, 32'h0);
    chk("mrst_hold_vld", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    step(1'b1, va[2], vb[2], vy[2], "post_rst");

    // Random traffic: sparse masks and repeated text bits to provoke ties.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) ra[15:0] = ra[15:0] & 16'($urandom);
      if (i % 4 == 0) rb = {rb[7:0], rb[7:0], rb[7:0], rb[7:0]};
      rv = ($urandom_range(0, 3) != 0);
      step(rv, ra, rb, model(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
